branch_resolve_unit: RTL

ID-stage branch resolution and recovery block that closes the loop for the IF-stage 1-bit/2-bit predictors. Evaluates each BEQ/BNE in ID against the prediction made for it, drives the same-cycle `pred_wrong` feedback to the predictor, and issues a registered front-end redirect and flush after a misprediction. Also emits a per-branch training write, indexed by PC, for a future pattern-history table, and keeps branch and misprediction statistics counters.

---
 rtl/branch_pkg.sv | 17 +
 rtl/branch_outcome.sv | 53 +++++
 rtl/branch_resolve_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared branch definitions: opcode constants used by the predictors and
// the resolve unit, plus the resolve/recover state encoding.
package branch_pkg;

    localparam logic [5:0] OPC_BEQ = 6'b000100;
    localparam logic [5:0] OPC_BNE = 6'b000101;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } brs_state_t;

    function automatic logic is_branch(input logic [5:0] opc);
        return (opc == OPC_BEQ) || (opc == OPC_BNE);
    endfunction

endpackage

// File: rtl/branch_outcome.sv
// Combinational branch evaluation: decode, actual outcome, misprediction
// flag and corrected fetch address for the instruction in ID.
module branch_outcome
    import branch_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            resolve_en,
    input  logic            id_valid,
    input  logic [5:0]      id_opcode,
    input  logic [PC_W-1:0] id_pc,
    input  logic [15:0]     id_imm,
    input  logic            id_equal,
    input  logic            id_pred_taken,
    output logic            res,
    output logic            taken,
    output logic            pred_wrong,
    output logic [PC_W-1:0] correct_pc
);

    logic [PC_W-1:0] pc_plus4_s;
    logic [PC_W-1:0] offset_s;

    assign pc_plus4_s = id_pc + PC_W'(4);
    // Word offset sign-extended to a byte offset; PC arithmetic wraps silently.
    assign offset_s   = {{(PC_W-18){id_imm[15]}}, id_imm, 2'b00};

    // Decode, outcome and redirect target
    always_comb begin
        res        = 1'b0;
        taken      = 1'b0;
        pred_wrong = 1'b0;
        correct_pc = pc_plus4_s;
        case (id_opcode)
            OPC_BEQ: taken = id_equal;
            OPC_BNE: taken = !id_equal;
            default: taken = 1'b0;
        endcase
        if (resolve_en && id_valid && is_branch(id_opcode)) begin
            res        = 1'b1;
            pred_wrong = id_pred_taken ^ taken;
        end else begin
            res        = 1'b0;
            pred_wrong = 1'b0;
        end
        if (taken) begin
            correct_pc = pc_plus4_s + offset_s;
        end else begin
            correct_pc = pc_plus4_s;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: misprediction feedback, registered redirect
// and flush, PC-indexed training write and saturating statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [PC_W-1:0]  id_pc,
    input  logic [15:0]      id_imm,
    input  logic             id_equal,
    input  logic             id_pred_taken,
    output logic             pred_wrong,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush,
    output logic             upd_valid,
    output logic [IDX_W-1:0] upd_idx,
    output logic             upd_taken,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    brs_state_t       state_r;
    logic             redirect_valid_r;
    logic [PC_W-1:0]  redirect_pc_r;
    logic             upd_valid_r;
    logic [IDX_W-1:0] upd_idx_r;
    logic             upd_taken_r;
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispred_cnt_r;

    logic             resolve_en_s;
    logic             res_s;
    logic             taken_s;
    logic             pred_wrong_s;
    logic [PC_W-1:0]  correct_pc_s;

    // ID holds wrong-path work while recovering, so nothing resolves then.
    assign resolve_en_s = !stall && (state_r == ST_IDLE);

    branch_outcome #(.PC_W(PC_W)) u_outcome (
        .resolve_en    (resolve_en_s),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_pc         (id_pc),
        .id_imm        (id_imm),
        .id_equal      (id_equal),
        .id_pred_taken (id_pred_taken),
        .res           (res_s),
        .taken         (taken_s),
        .pred_wrong    (pred_wrong_s),
        .correct_pc    (correct_pc_s)
    );

    // Recovery FSM with registered redirect request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (res_s && pred_wrong_s) begin
                        state_r          <= ST_RECOVER;
                        redirect_valid_r <= 1'b1;
                        redirect_pc_r    <= correct_pc_s;
                    end else begin
                        redirect_valid_r <= 1'b0;
                    end
                end
                ST_RECOVER: begin
                    if (!stall) begin
                        state_r          <= ST_IDLE;
                        redirect_valid_r <= 1'b0;
                    end else begin
                        redirect_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    redirect_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Training write pulse, one cycle after each resolve
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_valid_r <= 1'b0;
            upd_idx_r   <= '0;
            upd_taken_r <= 1'b0;
        end else if (res_s) begin
            upd_valid_r <= 1'b1;
            upd_idx_r   <= id_pc[IDX_W+1:2];
            upd_taken_r <= taken_s;
        end else begin
            upd_valid_r <= 1'b0;
        end
    end

    // Saturating branch and misprediction counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt_r  <= '0;
            mispred_cnt_r <= '0;
        end else begin
            if (res_s && (branch_cnt_r != CNT_MAX)) begin
                branch_cnt_r <= branch_cnt_r + CNT_ONE;
            end
            if (res_s && pred_wrong_s && (mispred_cnt_r != CNT_MAX)) begin
                mispred_cnt_r <= mispred_cnt_r + CNT_ONE;
            end
        end
    end

    assign pred_wrong     = pred_wrong_s;
    assign redirect_valid = redirect_valid_r;
    assign flush          = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign upd_valid      = upd_valid_r;
    assign upd_idx        = upd_idx_r;
    assign upd_taken      = upd_taken_r;
    assign branch_cnt     = branch_cnt_r;
    assign mispred_cnt    = mispred_cnt_r;

endmodule
